mult_datapath: RTL

MULT_DATAPATH -- requirements
Module: mult_datapath

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_counter.sv | 41 ++++
 rtl/mult_datapath.sv | 69 ++++++
 3 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants for the shift-add multiplier datapath
package mult_pkg;

   localparam int WIDTH_DEFAULT = 4;

   // Counter needs at least one bit even when the operand width is tiny.
   function automatic int cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   localparam int CNT_W    = cnt_w(WIDTH_DEFAULT);
   localparam int CNT_LAST = WIDTH_DEFAULT - 1;

endpackage

// File: rtl/mult_counter.sv
// rtl/mult_counter.sv - iteration counter, wraps at WIDTH-1 and flags the last shift
module mult_counter
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   localparam int CW   = cnt_w(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          last
);

   localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = (cnt_q == LAST_VAL) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == LAST_VAL);

endmodule

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - shift-add multiplier datapath: accumulator, multiplicand register, counter
module mult_datapath
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               ad,
   input  logic               sh,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic               m,
   output logic               k,
   output logic [2*WIDTH-1:0] product
);

   localparam int AW = 2 * WIDTH + 1;

   logic [AW-1:0]    acc_q;
   logic [AW-1:0]    acc_d;
   logic [WIDTH-1:0] mr_q;
   logic [WIDTH-1:0] mr_d;
   logic [WIDTH:0]   sum;
   logic [AW-1:0]    added;

   // The top accumulator bit is not an addend; it only receives the carry.
   assign sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mr_q};
   assign added = ad ? {sum, acc_q[WIDTH-1:0]} : acc_q;

   always_comb begin
      acc_d = acc_q;
      mr_d  = mr_q;
      if (load) begin
         acc_d = {{(WIDTH + 1){1'b0}}, mplier};
         mr_d  = mcand;
      end else if (sh) begin
         acc_d = {1'b0, added[AW-1:1]};
      end else begin
         acc_d = added;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         mr_q  <= '0;
      end else begin
         acc_q <= acc_d;
         mr_q  <= mr_d;
      end
   end

   mult_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (load),
      .inc  (sh & ~load),
      .cnt  (),
      .last (k)
   );

   assign m       = acc_q[0];
   assign product = acc_q[2*WIDTH-1:0];

endmodule
